// File: rtl/fxqi_pkg.sv
// Shared types and derived widths for the fx_quad_inv inverse-quadratic solver.
package fxqi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } fxqi_state_e;

  // Magnitude bits resolved by the bit-serial search (sign bit excluded).
  function automatic int unsigned fxqi_n(input int unsigned wi, input int unsigned wf);
    return wi + wf - 1;
  endfunction

  // Width of t^2 for a wx-bit operand.
  function automatic int unsigned fxqi_pw(input int unsigned wx);
    return 2 * wx;
  endfunction

  // Width of t^2 + t, one carry bit above the square.
  function automatic int unsigned fxqi_fw(input int unsigned wx);
    return 2 * wx + 1;
  endfunction

  function automatic int unsigned fxqi_wy(input int unsigned wi_y, input int unsigned wf_y);
    return wi_y + wf_y;
  endfunction

  function automatic int unsigned fxqi_iw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fx_quad_eval.sv
// Full-precision t^2 + t for an unsigned fixed-point t with WF fraction bits; result has 2*WF fraction bits.
module fx_quad_eval
  import fxqi_pkg::*;
#(
  parameter int unsigned WX = 16,
  parameter int unsigned WF = 8
) (
  input  logic [WX-1:0]         t_i,
  output logic [2*WX:0]         f_c_o
);

  localparam int unsigned PW = fxqi_pw(WX);
  localparam int unsigned FW = fxqi_fw(WX);

  logic [PW-1:0] sq;

  // t is shifted up by WF so both terms share the square's 2*WF fraction grid.
  always_comb begin
    sq    = PW'(t_i) * PW'(t_i);
    f_c_o = FW'(sq) + (FW'(t_i) << WF);
  end

endmodule

// File: rtl/fx_quad_inv.sv
// Bit-serial solver for the largest grid X >= 0 with X^2 + X <= Y.
// Optional residue output R = Y - (X^2 + X) when FXQI_RESIDUE_EN is defined.
module fx_quad_inv
  import fxqi_pkg::*;
#(
  parameter int unsigned WI   = 8,
  parameter int unsigned WF   = 8,
  parameter int unsigned WI_Y = 2*WI+1,
  parameter int unsigned WF_Y = 2*WF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        EN,
  input  logic                        START,
  input  logic signed [WI_Y+WF_Y-1:0] Y,
  output logic signed [WI+WF-1:0]     X,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ERR
`ifdef FXQI_RESIDUE_EN
  ,
  output logic signed [WI_Y+WF_Y-1:0] R
`endif
);

  localparam int unsigned WX = WI + WF;
  localparam int unsigned N  = fxqi_n(WI, WF);
  localparam int unsigned WY = fxqi_wy(WI_Y, WF_Y);
  localparam int unsigned FW = fxqi_fw(WX);
  localparam int unsigned CW = (WY > FW) ? WY : FW;
  localparam int unsigned IW = fxqi_iw(N);

  fxqi_state_e   state_q, state_d;
  logic [WY-1:0] y_q, y_d;
  logic [WX-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WX-1:0] x_q, x_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef FXQI_RESIDUE_EN
  logic [FW-1:0] fbest_q, fbest_d;
  logic [WY-1:0] r_q, r_d;
`endif

  logic [WX-1:0] trial;
  logic [FW-1:0] f_trial;
  logic          keep;
  logic [WX-1:0] acc_next;

  fx_quad_eval #(.WX(WX), .WF(WF)) u_eval (
    .t_i   (trial),
    .f_c_o (f_trial)
  );

  // Latched Y is known non-negative, so an unsigned compare is exact.
  always_comb begin
    trial    = acc_q | (WX'(1) << idx_q);
    keep     = CW'(f_trial) <= CW'(y_q);
    acc_next = keep ? trial : acc_q;
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    x_d     = x_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef FXQI_RESIDUE_EN
    fbest_d = fbest_q;
    r_d     = r_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          if (Y[WY-1]) begin
            x_d     = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FIN;
`ifdef FXQI_RESIDUE_EN
            r_d     = '0;
`endif
          end else begin
            y_d     = WY'(Y);
            acc_d   = '0;
            idx_d   = IW'(N-1);
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = ITER;
`ifdef FXQI_RESIDUE_EN
            fbest_d = '0;
`endif
          end
        end
      end
      ITER: begin
        acc_d = acc_next;
        idx_d = idx_q - IW'(1);
`ifdef FXQI_RESIDUE_EN
        if (keep) fbest_d = f_trial;
`endif
        if (idx_q == '0) begin
          x_d     = acc_next;
          done_d  = 1'b1;
          state_d = FIN;
`ifdef FXQI_RESIDUE_EN
          r_d     = y_q - WY'(keep ? f_trial : fbest_q);
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over EN; EN low freezes every register including DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      y_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef FXQI_RESIDUE_EN
      fbest_q <= '0;
      r_q     <= '0;
`endif
    end else if (EN) begin
      state_q <= state_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef FXQI_RESIDUE_EN
      fbest_q <= fbest_d;
      r_q     <= r_d;
`endif
    end
  end

  assign X    = x_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;
`ifdef FXQI_RESIDUE_EN
  assign R    = r_q;
`endif

endmodule

// File: tb/tb_fx_quad_inv.sv
// Directed and random checks of fx_quad_inv with a result scoreboard; R is checked when FXQI_RESIDUE_EN is defined.
module tb_fx_quad_inv;

  localparam int unsigned WI = 8;
  localparam int unsigned WF = 8;
  localparam int unsigned WX = WI + WF;
  localparam int unsigned WY = (2*WI+1) + 2*WF;
  localparam int unsigned N  = WX - 1;

  typedef struct {
    logic [WX-1:0] x;
    logic          err;
    logic [WY-1:0] r;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 start;
  logic signed [WY-1:0] y;
  logic signed [WX-1:0] x;
  logic                 busy;
  logic                 done;
  logic                 err;
`ifdef FXQI_RESIDUE_EN
  logic signed [WY-1:0] r;
`endif

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  fx_quad_inv #(.WI(WI), .WF(WF)) dut (
    .CLK   (clk),
    .RST   (rst),
    .EN    (en),
    .START (start),
    .Y     (y),
    .X     (x),
    .BUSY  (busy),
    .DONE  (done),
    .ERR   (err)
`ifdef FXQI_RESIDUE_EN
    ,
    .R     (r)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Brute-force reference: step x up while (x+1)^2 + (x+1)*2^WF still fits under y (all in 2^-2WF units).
  function automatic logic [WX-1:0] model_x(input logic signed [WY-1:0] yv);
    longint yl, xl, nx;
    if (yv < 0) return '0;
    yl = longint'(yv);
    xl = 0;
    forever begin
      nx = xl + 1;
      if (nx > 32767 || nx*nx + nx*(longint'(1) << WF) > yl) break;
      xl = nx;
    end
    return WX'(xl);
  endfunction

  function automatic exp_t make_exp(input logic signed [WY-1:0] yv, input logic [WX-1:0] xv);
    exp_t   e;
    longint xl;
    e.err = (yv < 0);
    e.x   = e.err ? '0 : xv;
    xl    = longint'(e.x);
    e.r   = e.err ? '0 : WY'(longint'(yv) - (xl*xl + xl*(longint'(1) << WF)));
    return e;
  endfunction

  task automatic start_op(input logic signed [WY-1:0] yv, input logic [WX-1:0] xv);
    sb.push_back(make_exp(yv, xv));
    @(negedge clk);
    y     = yv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges after the START edge until DONE is seen; optional EN stall / stray START.
  task automatic wait_done(input string tag, input int exp_edges, input int stall_at,
                           input int restart_at, input bit hold_fin);
    int   edges;
    exp_t e;
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (edges == 3) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (edges == stall_at) en = 1'b0;
      if (stall_at >= 0 && edges == stall_at + 3) en = 1'b1;
      if (edges == restart_at) begin
        start = 1'b1;
        y     = -WY'(65536);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    en    = 1'b1;
    check({tag, "_lat"}, 64'(edges), 64'(exp_edges));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_x"}, 64'(x), 64'(e.x));
      check({tag, "_err"}, 64'(err), 64'(e.err));
      check({tag, "_busy_fin"}, 64'(busy), 64'd0);
`ifdef FXQI_RESIDUE_EN
      check({tag, "_r"}, 64'(r), 64'(e.r));
      check({tag, "_r_sign"}, 64'(r[WY-1]), 64'd0);
`endif
      if (hold_fin) begin
        en = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_done_hold"}, 64'(done), 64'd1);
        en = 1'b1;
      end
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_x_hold"}, 64'(x), 64'(e.x));
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int highs;
    highs = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done === 1'b1) highs++;
    end
    check({tag, "_no_done"}, 64'(highs), 64'd0);
  endtask

  initial begin
    logic signed [WY-1:0] ry;
    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    y     = '0;
    repeat (3) @(negedge clk);
    check("rst_x", 64'(x), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    en  = 1'b1;

    start_op(WY'(131072), 16'h0100);       wait_done("y2p0", N, -1, -1, 1'b0);
    start_op(WY'(393216), 16'h0200);       wait_done("y6p0", N, -1, -1, 1'b0);
    start_op(WY'(49152), 16'h0080);        wait_done("y0p75", N, -1, -1, 1'b0);
    start_op(WY'(0), 16'h0000);            wait_done("y0", N, -1, -1, 1'b0);
    start_op(WY'(163840), 16'h0128);       wait_done("y2p5", N, -1, -1, 1'b1);
    // Negative Y: DONE rises on the START edge itself, visible in the very next cycle.
    start_op(-WY'(65536), 16'h0000);       wait_done("yneg", 0, -1, -1, 1'b0);
    start_op(WY'(131072), 16'h0100);       wait_done("err_clear", N, -1, -1, 1'b0);
    start_op(33'h0_FFFF_FFFF, 16'h7FFF);   wait_done("ymax", N, -1, -1, 1'b0);
    start_op(WY'(393216), 16'h0200);       wait_done("stall", N + 3, 5, -1, 1'b0);
    start_op(WY'(163840), 16'h0128);       wait_done("restart", N, -1, 7, 1'b0);
    expect_quiet("restart", 20);

    en    = 1'b0;
    y     = WY'(131072);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    en    = 1'b1;
    check("en_low_busy", 64'(busy), 64'd0);
    expect_quiet("en_low", 5);

    start_op(WY'(393216), 16'h0200);
    void'(sb.pop_back());
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_x", 64'(x), 64'd0);
    expect_quiet("abort", 20);
    start_op(WY'(49152), 16'h0080);        wait_done("post_abort", N, -1, -1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ry = {1'b0, 32'($urandom)};
      start_op(ry, model_x(ry));
      wait_done("rand", N, -1, -1, 1'(i == 1));
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fx_quad_inv.md
FX_QUAD_INV -- requirements
Module: fx_quad_inv

Interface
REQ-001 SHALL have parameter WI, 8, integer bits of X including sign.
REQ-002 SHALL have parameter WF, 8, fraction bits of X.
REQ-003 SHALL have parameter WI_Y, 2*WI+1, integer bits of Y including sign.
REQ-004 SHALL have parameter WF_Y, 2*WF, fraction bits of Y.
REQ-005 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-006 SHALL have port RST  input  1  synchronous reset, active-high.
REQ-007 SHALL have port EN  input  1  clock enable; low freezes all state.
REQ-008 SHALL have port START  input  1  request pulse, sampled in IDLE only.
REQ-009 SHALL have port Y  input  WI_Y+WF_Y  signed fixed-point operand.
REQ-010 SHALL have port X  output  WI+WF  signed fixed-point result, registered.
REQ-011 SHALL have port BUSY  output  1  high while in ITER.
REQ-012 SHALL have port DONE  output  1  high for one enabled cycle when X is valid.
REQ-013 SHALL have port ERR  output  1  Y was negative; registered.

Function
REQ-014 SHALL compute X = largest non-negative grid value (LSB 2^-WF) with X^2+X <= Y, inverting y = x^2 + x.
REQ-015 SHALL use FSM states IDLE, ITER, FIN.
REQ-016 SHALL, in IDLE with EN&START and Y>=0: latch Y, clear accumulator, set bit index to N-1 (N = WI+WF-1), go ITER.
REQ-017 SHALL, in IDLE with EN&START and Y<0: set X=0, ERR=1, go FIN directly; DONE is high 1 cycle after the START edge.
REQ-018 SHALL, per enabled ITER cycle: form trial = acc | (1<<idx); keep the bit if trial^2+trial <= latched Y; decrement idx.
REQ-019 SHALL go ITER->FIN on the edge evaluating idx==0; DONE is high N cycles after the START edge.
REQ-020 SHALL, in FIN, drive DONE=1 and return to IDLE on the next enabled edge.
REQ-021 SHALL evaluate trial^2+trial exactly: square at 2WF fraction bits, trial left-shifted WF to align, no truncation, no rounding.
REQ-022 SHALL keep the X sign bit 0; for Y >= f(max), X = 2^(WI-1)-2^-WF (all magnitude bits set).
REQ-023 SHALL update X on entry to FIN only; X and ERR hold until the next accepted START.
REQ-024 SHALL ignore START in ITER and FIN, and whenever EN=0.
REQ-025 SHALL hold all registers, including DONE, while EN=0.

Reset
REQ-026 SHALL, on RST high at a rising edge, force IDLE, X=0, BUSY=0, DONE=0, ERR=0 regardless of EN; this aborts any operation in progress.
REQ-027 SHALL give RST priority over START and EN.

Configuration
REQ-028 SHALL, with FXQI_RESIDUE_EN defined, add output R (WI_Y+WF_Y, signed) = Y - (X^2+X), registered with X; R = 0 on reset and on the ERR path.
REQ-029 SHALL, without FXQI_RESIDUE_EN, have no R port and no residue logic.

Structure
REQ-030 SHALL place the state enum and the derived widths (N, product width, Y width) in package fxqi_pkg.
REQ-031 SHALL use one combinational sub-module, fx_quad_eval, computing t^2+t at full precision for the comparison.

Verification
REQ-032 SHALL cover, with WI=8 and WF=8: Y=2.0 -> X=0x0100, ERR=0, DONE 15 cycles after START; Y=6.0 -> X=0x0200; Y=0.75 -> X=0x0080; Y=0 -> X=0x0000.
REQ-033 SHALL cover: Y=2.5 -> X=0x0128 (flooring); with FXQI_RESIDUE_EN, R=Y-(296/256)^2-296/256 >= 0.
REQ-034 SHALL cover: Y=-1.0 -> X=0, ERR=1, DONE 1 cycle after START; the next valid START clears ERR.
REQ-035 SHALL cover: Y=max positive -> X=0x7FFF.
REQ-036 SHALL cover: EN low for 3 cycles mid-ITER -> DONE delayed exactly 3 cycles with the same X; a second START during ITER -> ignored.
REQ-037 SHALL cover: RST asserted at ITER cycle 5 -> next cycle IDLE with X=0, BUSY=0, DONE=0; a subsequent START completes normally.
